// File: rtl/jtdsp16_hostif.sv
// -----------------------------------------------------------------------------
// jtdsp16_hostif
//
// Host-to-DSP16 command bridge. The host CPU writes 24-bit command entries
// (8-bit address + 16-bit data) into a 4-deep FIFO through three byte
// registers. An interrupt is raised to the DSP while entries are pending. The
// DSP acknowledges, reads the address byte (psel=0) and the data word (psel=1)
// from its parallel input bus, and the psel=1 read pops the entry. In the
// other direction, the DSP can write one 16-bit word back (pods_n strobe),
// which the host reads as two bytes.
//
// Optional feature: define JTDSP16_HOSTIF_STATUS_EN to make host address 3
// return a status byte {rb_valid, ovf, tmo, 2'b0, level}. Reading it clears
// ovf and tmo. Without the macro that address reads as zero, but the flags
// and the timeout logic keep running.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   cen2              DSP instruction-rate enable (timeout counter only)
//   host_wr, host_rd  one-clk host strobes
//   host_addr[1:0]    0 data hi, 1 data lo, 2 address/commit, 3 status
//   host_din[7:0]     host write data
//   host_dout[7:0]    host read data, registered, valid the clk after host_rd
//   host_full         command FIFO holds 4 entries
//   pbus_in[15:0]     word presented to the DSP parallel input bus
//   pbus_out[15:0]    DSP parallel output bus
//   pids_n, pods_n    DSP parallel input/output strobes (active low)
//   psel              DSP parallel select (0 address byte, 1 data word)
//   irq, iack         interrupt request to the DSP and its acknowledge
//   dbg_state_o       FSM state (0 IDLE, 1 REQ, 2 XFER)
//   dbg_level_o       FIFO occupancy 0..4
//   dbg_ovf_o         sticky overflow flag
//   dbg_tmo_o         sticky interrupt-timeout flag
//   dbg_rb_valid_o    read-back word pending for the host
//
// Handshake: there is no valid/ready backpressure on either side. A host
// strobe is a one-clk command that is always consumed in its cycle; a commit
// into a full FIFO is discarded and reported through ovf. The DSP side
// transfers on the rising edge (end) of its strobes.
// -----------------------------------------------------------------------------
module jtdsp16_hostif (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen2,
  input  logic        host_wr,
  input  logic        host_rd,
  input  logic [1:0]  host_addr,
  input  logic [7:0]  host_din,
  output logic [7:0]  host_dout,
  output logic        host_full,
  output logic [15:0] pbus_in,
  input  logic [15:0] pbus_out,
  input  logic        pids_n,
  input  logic        pods_n,
  input  logic        psel,
  output logic        irq,
  input  logic        iack,
  output logic [1:0]  dbg_state_o,
  output logic [2:0]  dbg_level_o,
  output logic        dbg_ovf_o,
  output logic        dbg_tmo_o,
  output logic        dbg_rb_valid_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  localparam logic [9:0] TMO_LAST = 10'd1023;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [23:0] fifo_q [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  level_q, level_d;
  logic [7:0]  dhi_q, dhi_d;
  logic [7:0]  dlo_q, dlo_d;
  logic [15:0] rb_q, rb_d;
  logic        rb_valid_q, rb_valid_d;
  logic        ovf_q, ovf_d;
  logic        tmo_q, tmo_d;
  logic [7:0]  dout_q, dout_d;
  logic        pids_q, pods_q;
  logic [9:0]  tmo_cnt_q;
  state_t      state_q;
  logic        irq_q;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  logic        fifo_empty;
  logic        fifo_full;
  logic [23:0] head;
  logic        pids_rise, pods_rise;
  logic        pop, push_req, push, drop;
  logic        tmo_hit;
  logic        stat_clr;
  logic [7:0]  rd_data;

  assign fifo_empty = (level_q == 3'd0);
  assign fifo_full  = (level_q == 3'd4);
  assign head       = fifo_q[rd_ptr_q];

  // A strobe ends when the live pin is high and the previous sample was low.
  assign pids_rise = pids_n & ~pids_q;
  assign pods_rise = pods_n & ~pods_q;

  assign pop      = (state_q == ST_XFER) && pids_rise && psel;
  assign push_req = host_wr && (host_addr == 2'd2);
  // A full FIFO still accepts a commit when the head leaves in the same
  // cycle: the new entry lands in the slot being freed, which becomes the tail.
  assign push     = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;

  // Acknowledge wins over a timeout that matures in the same cycle.
  assign tmo_hit  = (state_q == ST_REQ) && !iack && (tmo_cnt_q == TMO_LAST);

`ifdef JTDSP16_HOSTIF_STATUS_EN
  assign stat_clr = host_rd && (host_addr == 2'd3);
`else
  assign stat_clr = 1'b0;
`endif

  always_comb begin
    rd_data = 8'd0;
    case (host_addr)
      2'd0:    rd_data = rb_q[15:8];
      2'd1:    rd_data = rb_q[7:0];
      2'd2:    rd_data = 8'd0;
      default: begin
`ifdef JTDSP16_HOSTIF_STATUS_EN
        rd_data = {rb_valid_q, ovf_q, tmo_q, 2'b00, level_q};
`else
        rd_data = 8'd0;
`endif
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state for datapath registers
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
    level_d    = level_q + {2'b00, push} - {2'b00, pop};

    dhi_d      = (host_wr && host_addr == 2'd0) ? host_din : dhi_q;
    dlo_d      = (host_wr && host_addr == 2'd1) ? host_din : dlo_q;

    rb_d       = pods_rise ? pbus_out : rb_q;
    // A new DSP word takes priority over the host consuming the old one.
    rb_valid_d = rb_valid_q;
    if (host_rd && host_addr == 2'd1) rb_valid_d = 1'b0;
    if (pods_rise)                    rb_valid_d = 1'b1;

    // Setting events take priority over a status-read clear.
    ovf_d      = drop    ? 1'b1 : (stat_clr ? 1'b0 : ovf_q);
    tmo_d      = tmo_hit ? 1'b1 : (stat_clr ? 1'b0 : tmo_q);

    dout_d     = host_rd ? rd_data : dout_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) fifo_q[i] <= 24'd0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      level_q    <= 3'd0;
      dhi_q      <= 8'd0;
      dlo_q      <= 8'd0;
      rb_q       <= 16'd0;
      rb_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
      dout_q     <= 8'd0;
      pids_q     <= 1'b1;
      pods_q     <= 1'b1;
    end else begin
      if (push) fifo_q[wr_ptr_q] <= {host_din, dhi_q, dlo_q};
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      dhi_q      <= dhi_d;
      dlo_q      <= dlo_d;
      rb_q       <= rb_d;
      rb_valid_q <= rb_valid_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
      dout_q     <= dout_d;
      pids_q     <= pids_n;
      pods_q     <= pods_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt FSM with registered irq and the REQ timeout counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      irq_q     <= 1'b0;
      tmo_cnt_q <= 10'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tmo_cnt_q <= 10'd0;
          if (!fifo_empty) begin
            state_q <= ST_REQ;
            irq_q   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (iack) begin
            state_q   <= ST_XFER;
            irq_q     <= 1'b0;
            tmo_cnt_q <= 10'd0;
          end else if (tmo_hit) begin
            // Give up on this request; the entry stays queued so IDLE
            // re-raises irq on the following cycle.
            state_q   <= ST_IDLE;
            irq_q     <= 1'b0;
            tmo_cnt_q <= 10'd0;
          end else if (cen2) begin
            tmo_cnt_q <= tmo_cnt_q + 10'd1;
          end
        end
        ST_XFER: begin
          tmo_cnt_q <= 10'd0;
          if (pop) state_q <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          irq_q     <= 1'b0;
          tmo_cnt_q <= 10'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    pbus_in = 16'd0;
    if (!fifo_empty) pbus_in = psel ? head[15:0] : {8'd0, head[23:16]};
  end

  assign host_dout      = dout_q;
  assign host_full      = fifo_full;
  assign irq            = irq_q;
  assign dbg_state_o    = state_q;
  assign dbg_level_o    = level_q;
  assign dbg_ovf_o      = ovf_q;
  assign dbg_tmo_o      = tmo_q;
  assign dbg_rb_valid_o = rb_valid_q;

endmodule

// File: tb/tb_jtdsp16_hostif.sv
// -----------------------------------------------------------------------------
// tb_jtdsp16_hostif
//
// Exercises the host command FIFO, the DSP interrupt/transfer sequence, the
// interrupt timeout, the DSP read-back path and reset behaviour. A queue of
// pending 24-bit commands plus a few flags model the expected behaviour.
// -----------------------------------------------------------------------------
module tb_jtdsp16_hostif;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen2 = 1'b0;
  logic        host_wr = 1'b0;
  logic        host_rd = 1'b0;
  logic [1:0]  host_addr = 2'd0;
  logic [7:0]  host_din = 8'd0;
  logic [7:0]  host_dout;
  logic        host_full;
  logic [15:0] pbus_in;
  logic [15:0] pbus_out = 16'd0;
  logic        pids_n = 1'b1;
  logic        pods_n = 1'b1;
  logic        psel = 1'b0;
  logic        irq;
  logic        iack = 1'b0;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_level;
  logic        dbg_ovf;
  logic        dbg_tmo;
  logic        dbg_rb_valid;

  always #5 clk = ~clk;

  jtdsp16_hostif dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cen2           (cen2),
    .host_wr        (host_wr),
    .host_rd        (host_rd),
    .host_addr      (host_addr),
    .host_din       (host_din),
    .host_dout      (host_dout),
    .host_full      (host_full),
    .pbus_in        (pbus_in),
    .pbus_out       (pbus_out),
    .pids_n         (pids_n),
    .pods_n         (pods_n),
    .psel           (psel),
    .irq            (irq),
    .iack           (iack),
    .dbg_state_o    (dbg_state),
    .dbg_level_o    (dbg_level),
    .dbg_ovf_o      (dbg_ovf),
    .dbg_tmo_o      (dbg_tmo),
    .dbg_rb_valid_o (dbg_rb_valid)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (time=%0t, limit=2000000)", $time);
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int          total = 0;
  int          bad = 0;
  logic [23:0] exp_q[$];
  logic [7:0]  m_dhi, m_dlo;
  logic [15:0] m_rb;
  logic        m_rbv, m_ovf, m_tmo;

  task automatic model_reset();
    exp_q.delete();
    m_dhi = 8'd0; m_dlo = 8'd0; m_rb = 16'd0;
    m_rbv = 1'b0; m_ovf = 1'b0; m_tmo = 1'b0;
  endtask

  function automatic logic [7:0] exp_read(input logic [1:0] a);
    logic [7:0] r;
    r = 8'd0;
    case (a)
      2'd0: r = m_rb[15:8];
      2'd1: r = m_rb[7:0];
      2'd2: r = 8'd0;
      default: begin
`ifdef JTDSP16_HOSTIF_STATUS_EN
        r = {m_rbv, m_ovf, m_tmo, 2'b00, 3'(exp_q.size())};
`else
        r = 8'd0;
`endif
      end
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (all start and end on a negedge)
  // ---------------------------------------------------------------------------
  task automatic host_write(input logic [1:0] a, input logic [7:0] d);
    host_addr = a; host_din = d; host_wr = 1'b1;
    @(negedge clk);
    host_wr = 1'b0;
    case (a)
      2'd0: m_dhi = d;
      2'd1: m_dlo = d;
      2'd2: if (exp_q.size() < 4) exp_q.push_back({d, m_dhi, m_dlo}); else m_ovf = 1'b1;
      default: ;
    endcase
  endtask

  task automatic host_push(input logic [23:0] e);
    host_write(2'd0, e[15:8]);
    host_write(2'd1, e[7:0]);
    host_write(2'd2, e[23:16]);
  endtask

  task automatic host_read(input logic [1:0] a, output logic [7:0] d);
    host_addr = a; host_rd = 1'b1;
    @(negedge clk);
    host_rd = 1'b0;
    d = host_dout;
    if (a == 2'd1) m_rbv = 1'b0;
`ifdef JTDSP16_HOSTIF_STATUS_EN
    if (a == 2'd3) begin m_ovf = 1'b0; m_tmo = 1'b0; end
`endif
  endtask

  // Bounded wait for irq; an expired bound counts as a failed comparison.
  task automatic wait_irq(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (irq === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL wait_irq: irq=%b after 2000 cycles, required 1", irq);
    end
  endtask

  // One DSP parallel-input strobe; returns pbus_in seen while the strobe is low.
  task automatic dsp_pids(input logic sel, output logic [15:0] seen);
    psel = sel; pids_n = 1'b0;
    @(negedge clk);
    seen = pbus_in;
    pids_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic dsp_pods(input logic [15:0] v);
    pbus_out = v; pods_n = 1'b0;
    @(negedge clk);
    pods_n = 1'b1;
    @(negedge clk);
    m_rb = v; m_rbv = 1'b1;
  endtask

  // Full DSP transaction: wait for irq, acknowledge, read address then data.
  task automatic drain_one(output logic [15:0] s0, output logic [15:0] s1, output logic ok);
    s0 = 16'd0; s1 = 16'd0;
    wait_irq(ok);
    if (ok) begin
      iack = 1'b1;
      @(negedge clk);
      iack = 1'b0;
      dsp_pids(1'b0, s0);
      dsp_pids(1'b1, s1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    total++; if (host_full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", host_full); end
    total++; if (host_dout !== 8'h00) begin bad++; $display("FAIL reset_dout: got %h want 00", host_dout); end
    psel = 1'b1; #1;
    total++; if (pbus_in !== 16'h0000) begin bad++; $display("FAIL reset_pbus_psel1: got %h want 0000", pbus_in); end
    psel = 1'b0; #1;
    total++; if (pbus_in !== 16'h0000) begin bad++; $display("FAIL reset_pbus_psel0: got %h want 0000", pbus_in); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    total++; if (dbg_level !== 3'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", dbg_level); end
  endtask

  task automatic test_basic();
    logic ok;
    logic [15:0] s;
    host_write(2'd0, 8'h12);
    host_write(2'd1, 8'h34);
    host_write(2'd2, 8'h56);
    wait_irq(ok);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL basic_irq_up: got %b want 1", irq); end
    iack = 1'b1;
    @(negedge clk);
    iack = 1'b0;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL basic_irq_ack: got %b want 0", irq); end
    total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL basic_xfer: got %0d want 2", dbg_state); end
    dsp_pids(1'b0, s);
    total++; if (s !== 16'h0056) begin bad++; $display("FAIL basic_addr: got %h want 0056", s); end
    total++; if (dbg_level !== 3'd1) begin bad++; $display("FAIL basic_level_keep: got %0d want 1", dbg_level); end
    dsp_pids(1'b1, s);
    total++; if (s !== 16'h1234) begin bad++; $display("FAIL basic_data: got %h want 1234", s); end
    void'(exp_q.pop_front());
    total++; if (dbg_level !== 3'(exp_q.size())) begin bad++; $display("FAIL basic_level_end: got %0d want %0d", dbg_level, exp_q.size()); end
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL basic_irq_idle: got %b want 0", irq); end
  endtask

  task automatic test_overflow();
    logic ok;
    logic [15:0] s0, s1;
    logic [7:0] r, e;
    logic [23:0] h;
    for (int i = 0; i < 5; i++) begin
      host_push(24'($urandom));
      if (i == 2) begin
        total++; if (host_full !== 1'b0) begin bad++; $display("FAIL ovf_full3: got %b want 0", host_full); end
      end
      if (i == 3) begin
        total++; if (host_full !== 1'b1) begin bad++; $display("FAIL ovf_full4: got %b want 1", host_full); end
      end
    end
    total++; if (dbg_level !== 3'd4) begin bad++; $display("FAIL ovf_level: got %0d want 4", dbg_level); end
    total++; if (dbg_ovf !== m_ovf) begin bad++; $display("FAIL ovf_flag: got %b want %b", dbg_ovf, m_ovf); end
    e = exp_read(2'd3);
    host_read(2'd3, r);
    total++; if (r !== e) begin bad++; $display("FAIL ovf_status1: got %h want %h", r, e); end
`ifdef JTDSP16_HOSTIF_STATUS_EN
    total++; if (r !== 8'h44) begin bad++; $display("FAIL ovf_status_44: got %h want 44", r); end
`endif
    e = exp_read(2'd3);
    host_read(2'd3, r);
    total++; if (r !== e) begin bad++; $display("FAIL ovf_status2: got %h want %h", r, e); end
    total++; if (dbg_ovf !== m_ovf) begin bad++; $display("FAIL ovf_after_read: got %b want %b", dbg_ovf, m_ovf); end
    while (exp_q.size() > 0) begin
      h = exp_q.pop_front();
      drain_one(s0, s1, ok);
      if (!ok) break;
      total++; if (s0 !== {8'd0, h[23:16]} || s1 !== h[15:0]) begin
        bad++; $display("FAIL ovf_drain: got %h/%h want %h/%h", s0, s1, {8'd0, h[23:16]}, h[15:0]);
      end
    end
    total++; if (dbg_level !== 3'd0) begin bad++; $display("FAIL ovf_empty: got %0d want 0", dbg_level); end
  endtask

  task automatic test_full_pop_push();
    logic ok;
    logic [15:0] s, s0, s1;
    logic [23:0] h, nd;
    for (int i = 0; i < 4; i++) host_push(24'($urandom));
    wait_irq(ok);
    iack = 1'b1;
    @(negedge clk);
    iack = 1'b0;
    nd = 24'($urandom);
    host_write(2'd0, nd[15:8]);
    host_write(2'd1, nd[7:0]);
    h = exp_q[0];
    // Strobe end and commit land on the same clock edge.
    psel = 1'b1; pids_n = 1'b0;
    @(negedge clk);
    s = pbus_in;
    pids_n = 1'b1;
    host_addr = 2'd2; host_din = nd[23:16]; host_wr = 1'b1;
    @(negedge clk);
    host_wr = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(nd);
    total++; if (s !== h[15:0]) begin bad++; $display("FAIL fpp_head: got %h want %h", s, h[15:0]); end
    total++; if (dbg_level !== 3'd4) begin bad++; $display("FAIL fpp_level: got %0d want 4", dbg_level); end
    total++; if (host_full !== 1'b1) begin bad++; $display("FAIL fpp_full: got %b want 1", host_full); end
    total++; if (dbg_ovf !== m_ovf) begin bad++; $display("FAIL fpp_ovf: got %b want %b", dbg_ovf, m_ovf); end
    while (exp_q.size() > 0) begin
      h = exp_q.pop_front();
      drain_one(s0, s1, ok);
      if (!ok) break;
      total++; if (s0 !== {8'd0, h[23:16]} || s1 !== h[15:0]) begin
        bad++; $display("FAIL fpp_drain: got %h/%h want %h/%h", s0, s1, {8'd0, h[23:16]}, h[15:0]);
      end
    end
  endtask

  task automatic test_timeout();
    logic ok;
    logic [15:0] s0, s1;
    logic [7:0] r, e;
    logic [23:0] h;
    int n;
    cen2 = 1'b1;
    host_push(24'($urandom));
    wait_irq(ok);
    n = 0;
    while (irq === 1'b1 && n < 1200) begin
      n++;
      @(negedge clk);
    end
    // With cen2 held high the request should last about 1023 ticks.
    total++; if (n < 1023 || n > 1026) begin bad++; $display("FAIL tmo_len: got %0d cycles want 1023..1026", n); end
    m_tmo = 1'b1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL tmo_irq_low: got %b want 0", irq); end
    total++; if (dbg_tmo !== 1'b1) begin bad++; $display("FAIL tmo_flag: got %b want 1", dbg_tmo); end
    total++; if (dbg_level !== 3'd1) begin bad++; $display("FAIL tmo_level: got %0d want 1", dbg_level); end
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL tmo_irq_again: got %b want 1", irq); end
    psel = 1'b1; #1;
    total++; if (pbus_in !== exp_q[0][15:0]) begin bad++; $display("FAIL tmo_head: got %h want %h", pbus_in, exp_q[0][15:0]); end
    @(negedge clk);
    e = exp_read(2'd3);
    host_read(2'd3, r);
    total++; if (r !== e) begin bad++; $display("FAIL tmo_status: got %h want %h", r, e); end
    total++; if (dbg_tmo !== m_tmo) begin bad++; $display("FAIL tmo_after_read: got %b want %b", dbg_tmo, m_tmo); end
    h = exp_q.pop_front();
    drain_one(s0, s1, ok);
    if (ok) begin
      total++; if (s0 !== {8'd0, h[23:16]} || s1 !== h[15:0]) begin
        bad++; $display("FAIL tmo_drain: got %h/%h want %h/%h", s0, s1, {8'd0, h[23:16]}, h[15:0]);
      end
    end
  endtask

  task automatic test_readback();
    logic [7:0] r, e;
    logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      v = (i == 0) ? 16'hBEEF : 16'($urandom);
      cen2 = 1'($urandom);
      dsp_pods(v);
      total++; if (dbg_rb_valid !== 1'b1) begin bad++; $display("FAIL rb_valid_set: got %b want 1", dbg_rb_valid); end
      e = exp_read(2'd0);
      host_read(2'd0, r);
      total++; if (r !== e) begin bad++; $display("FAIL rb_hi: got %h want %h", r, e); end
      e = exp_read(2'd2);
      host_read(2'd2, r);
      total++; if (r !== e) begin bad++; $display("FAIL rb_addr2: got %h want %h", r, e); end
      total++; if (dbg_rb_valid !== 1'b1) begin bad++; $display("FAIL rb_valid_hold: got %b want 1", dbg_rb_valid); end
      e = exp_read(2'd1);
      host_read(2'd1, r);
      total++; if (r !== e) begin bad++; $display("FAIL rb_lo: got %h want %h", r, e); end
      total++; if (dbg_rb_valid !== m_rbv) begin bad++; $display("FAIL rb_valid_clr: got %b want %b", dbg_rb_valid, m_rbv); end
    end
  endtask

  task automatic test_random();
    logic ok;
    logic [15:0] s0, s1, sp;
    logic [23:0] h;
    int k;
    for (int round = 0; round < 4; round++) begin
      cen2 = 1'($urandom);
      k = $urandom_range(1, 4);
      for (int i = 0; i < k; i++) begin
        if ($urandom_range(0, 2) == 0) host_write(2'd3, 8'($urandom));
        host_push(24'($urandom));
      end
      total++; if (dbg_level !== 3'(exp_q.size())) begin bad++; $display("FAIL rnd_level: got %0d want %0d", dbg_level, exp_q.size()); end
      while (exp_q.size() > 0) begin
        h = exp_q.pop_front();
        drain_one(s0, s1, ok);
        if (!ok) break;
        total++; if (s0 !== {8'd0, h[23:16]} || s1 !== h[15:0]) begin
          bad++; $display("FAIL rnd_drain: got %h/%h want %h/%h", s0, s1, {8'd0, h[23:16]}, h[15:0]);
        end
        // A psel=0 strobe outside XFER must not disturb the queue.
        if (exp_q.size() > 0) begin
          @(negedge clk);
          dsp_pids(1'b0, sp);
          total++; if (dbg_level !== 3'(exp_q.size())) begin bad++; $display("FAIL rnd_probe: got %0d want %0d", dbg_level, exp_q.size()); end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic ok;
    logic [15:0] s0, s1;
    logic [23:0] h;
    host_push(24'($urandom));
    host_push(24'($urandom));
    wait_irq(ok);
    iack = 1'b1;
    @(negedge clk);
    iack = 1'b0;
    total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL rstmid_xfer: got %0d want 2", dbg_state); end
    psel = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rstmid_irq: got %b want 0", irq); end
    total++; if (dbg_level !== 3'd0) begin bad++; $display("FAIL rstmid_level: got %0d want 0", dbg_level); end
    total++; if (pbus_in !== 16'h0000) begin bad++; $display("FAIL rstmid_pbus: got %h want 0000", pbus_in); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rstmid_idle: got %0d want 0", dbg_state); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rstmid_noirq: got %b want 0", irq); end
    host_push(24'($urandom));
    h = exp_q.pop_front();
    drain_one(s0, s1, ok);
    if (ok) begin
      total++; if (s0 !== {8'd0, h[23:16]} || s1 !== h[15:0]) begin
        bad++; $display("FAIL rstmid_recover: got %h/%h want %h/%h", s0, s1, {8'd0, h[23:16]}, h[15:0]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_overflow();
    test_full_pop_push();
    test_timeout();
    test_readback();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
